// File: rtl/add_sub_seq_ctrl_if.sv
// rtl/add_sub_seq_ctrl_if.sv - request/response and shared-adder signals of the wide add/sub sequencer
interface add_sub_seq_if #(
  parameter int WORDS = 2
);
  localparam int W = 32 * WORDS;

  logic         req_valid;
  logic         req_ready;
  logic         req_sub;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic [31:0]  add_x;
  logic [31:0]  add_y;
  logic         add_cin;
  logic [31:0]  add_s;
  logic         add_cout;

  // slave: the sequencer; master: requester plus the shared full_adder_32
  modport slave (
    input  req_valid, req_sub, req_a, req_b, rsp_ready, add_s, add_cout,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, add_x, add_y, add_cin
  );

  modport master (
    output req_valid, req_sub, req_a, req_b, rsp_ready, add_s, add_cout,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, add_x, add_y, add_cin
  );
endinterface

// File: rtl/add_sub_seq_ctrl.sv
// rtl/add_sub_seq_ctrl.sv - wide add/sub sequencer driving one shared 32-bit adder, LSW first
// Define ADD_SEQ_OVF_EN to generate signed-overflow detection on rsp_ovf.
module add_sub_seq_ctrl #(
  parameter int WORDS = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  add_sub_seq_if.slave   bus
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [WORDS-1:0][31:0] a_q, a_d;
  logic [WORDS-1:0][31:0] b_q, b_d;
  logic [WORDS-1:0][31:0] sum_q, sum_d;
  logic                   cout_q, cout_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   last_word;
`ifdef ADD_SEQ_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  assign last_word = (idx_q == IDXW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Subtraction is folded into an add: B inverted here, +1 via the initial carry.
          a_d     = bus.req_a;
          b_d     = bus.req_sub ? ~bus.req_b : bus.req_b;
          carry_d = bus.req_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = bus.add_s;
        carry_d      = bus.add_cout;
        if (last_word) begin
          cout_d  = bus.add_cout;
`ifdef ADD_SEQ_OVF_EN
          ovf_d   = (a_q[WORDS-1][31] == b_q[WORDS-1][31]) &&
                    (bus.add_s[31] != a_q[WORDS-1][31]);
`endif
          idx_d   = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
`ifdef ADD_SEQ_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`else
  assign bus.rsp_ovf   = 1'b0;
`endif

  // Adder inputs are quiet outside RUN so the shared adder sees no spurious activity.
  assign bus.add_x   = (state_q == RUN) ? a_q[idx_q] : 32'h0;
  assign bus.add_y   = (state_q == RUN) ? b_q[idx_q] : 32'h0;
  assign bus.add_cin = (state_q == RUN) ? carry_q    : 1'b0;
endmodule
